// File: rtl/simram_port_arbiter_if.sv
// Requester-side and RAM-side bundles for the simulation RAM port arbiter.
// The arbiter takes the slave view of each requester and the master view of the RAM port.
interface simram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
);
    logic                    req;
    logic [DATA_WIDTH/8-1:0] wen;
    logic [BUS_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    lock;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, wen, addr, wdata, lock, input gnt, rvalid, rdata);
    modport slave  (input req, wen, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

interface simram_port_arbiter_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
);
    logic                    ren;
    logic [BUS_WIDTH-1:0]    raddr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH/8-1:0] wen;
    logic [BUS_WIDTH-1:0]    waddr;
    logic [DATA_WIDTH-1:0]   wdata;

    modport master (output ren, raddr, wen, waddr, wdata, input rdata);
    modport slave  (input ren, raddr, wen, waddr, wdata, output rdata);
endinterface

// File: rtl/simram_port_arbiter.sv
// Two-requester round-robin arbiter for the simulation RAM port, with burst lock,
// starvation timeout and read-data steering back to the issuing requester.
module simram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    simram_port_arbiter_if.slave      m0,
    simram_port_arbiter_if.slave      m1,
    simram_port_arbiter_ram_if.master ram,
    output logic [1:0]                owner
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOCK0 = 2'b01,
        ST_LOCK1 = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr;
    logic               w_rr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_rd_pend;
    logic               r_rd_tag;

    logic               w_pick0;
    logic               w_pick1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_any;
    logic               w_is_read;
    logic               w_sel_lock;
    logic [BE_W-1:0]    w_sel_wen;
    logic [BUS_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Winner selection; a locked owner is refused on the cycle its hold budget runs out.
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0.req && m1.req) begin
                    w_pick0 = r_rr;
                    w_pick1 = ~r_rr;
                end else begin
                    w_pick0 = m0.req;
                    w_pick1 = m1.req;
                end
            end
            ST_LOCK0: w_pick0 = m0.req && (r_cnt != CNT_MAX);
            ST_LOCK1: w_pick1 = m1.req && (r_cnt != CNT_MAX);
            default: begin
                w_pick0 = 1'b0;
                w_pick1 = 1'b0;
            end
        endcase
    end

    assign w_gnt0 = w_pick0 & ~areset;
    assign w_gnt1 = w_pick1 & ~areset;
    assign w_any  = w_gnt0 | w_gnt1;

    // Steer the granted beat onto the RAM port; everything reads as zero without a grant.
    always_comb begin
        w_sel_wen   = {BE_W{1'b0}};
        w_sel_addr  = {BUS_WIDTH{1'b0}};
        w_sel_wdata = {DATA_WIDTH{1'b0}};
        w_sel_lock  = 1'b0;
        if (w_gnt0) begin
            w_sel_wen   = m0.wen;
            w_sel_addr  = m0.addr;
            w_sel_wdata = m0.wdata;
            w_sel_lock  = m0.lock;
        end else if (w_gnt1) begin
            w_sel_wen   = m1.wen;
            w_sel_addr  = m1.addr;
            w_sel_wdata = m1.wdata;
            w_sel_lock  = m1.lock;
        end else begin
            w_sel_lock  = 1'b0;
        end
    end

    assign w_is_read = w_any && (w_sel_wen == {BE_W{1'b0}});

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign ram.ren   = w_is_read;
    assign ram.raddr = w_sel_addr;
    assign ram.waddr = w_sel_addr;
    assign ram.wdata = w_sel_wdata;
    assign ram.wen   = w_sel_wen;

    assign m0.rvalid = r_rd_pend & ~r_rd_tag & ~areset;
    assign m1.rvalid = r_rd_pend &  r_rd_tag & ~areset;
    assign m0.rdata  = m0.rvalid ? ram.rdata : {DATA_WIDTH{1'b0}};
    assign m1.rdata  = m1.rvalid ? ram.rdata : {DATA_WIDTH{1'b0}};

    assign owner = r_state;

    // Lock/timeout bookkeeping; timeout hands rr to the owner so the peer wins next.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOCK0: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b0;
                end else if (m1.req) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_LOCK1: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b1;
                end else if (m0.req) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: w_cnt_nxt = r_cnt;
        endcase
        if (w_any) begin
            w_rr_nxt = w_gnt1;
            if (w_sel_lock) begin
                w_state_nxt = w_gnt1 ? ST_LOCK1 : ST_LOCK0;
                if (w_state_nxt != r_state) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt = w_cnt_nxt;
                end
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_rr_nxt = w_rr_nxt;
        end
    end

    // State, round-robin pointer, hold counter and read-return tracking.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b1;
            r_cnt     <= {CNT_W{1'b0}};
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_is_read;
            r_rd_tag  <= w_gnt1;
        end
    end
endmodule

// File: tb/tb_simram_port_arbiter.sv
// Scenario tasks drive both arbiters; a read scoreboard checks every returned beat.
module tb_simram_port_arbiter;
    logic       aclk   = 1'b0;
    logic       areset = 1'b1;
    logic [1:0] owner_a;
    logic [1:0] owner_b;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    typedef struct {
        logic        tag;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    simram_port_arbiter_if     #(.DATA_WIDTH(32), .BUS_WIDTH(32)) m0_if ();
    simram_port_arbiter_if     #(.DATA_WIDTH(32), .BUS_WIDTH(32)) m1_if ();
    simram_port_arbiter_ram_if #(.DATA_WIDTH(32), .BUS_WIDTH(32)) ram_if ();
    simram_port_arbiter_if     #(.DATA_WIDTH(32), .BUS_WIDTH(32)) n0_if ();
    simram_port_arbiter_if     #(.DATA_WIDTH(32), .BUS_WIDTH(32)) n1_if ();
    simram_port_arbiter_ram_if #(.DATA_WIDTH(32), .BUS_WIDTH(32)) ram4_if ();

    simram_port_arbiter #(.DATA_WIDTH(32), .BUS_WIDTH(32), .MAX_HOLD(16)) u_dut (
        .aclk(aclk), .areset(areset), .m0(m0_if), .m1(m1_if), .ram(ram_if), .owner(owner_a));
    simram_port_arbiter #(.DATA_WIDTH(32), .BUS_WIDTH(32), .MAX_HOLD(4)) u_dut4 (
        .aclk(aclk), .areset(areset), .m0(n0_if), .m1(n1_if), .ram(ram4_if), .owner(owner_b));

    always #5 aclk = ~aclk;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        ram_val = (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // RAM model: one-cycle read latency
    always @(posedge aclk) ram_if.rdata <= ram_if.ren ? ram_val(ram_if.raddr) : 32'h0;
    assign ram4_if.rdata = 32'h0;

    task automatic idle_all();
        m0_if.req = 1'b0; m0_if.wen = 4'h0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.lock = 1'b0;
        m1_if.req = 1'b0; m1_if.wen = 4'h0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0; m1_if.lock = 1'b0;
        n0_if.req = 1'b0; n0_if.wen = 4'h0; n0_if.addr = 32'h0; n0_if.wdata = 32'h0; n0_if.lock = 1'b0;
        n1_if.req = 1'b0; n1_if.wen = 4'h0; n1_if.addr = 32'h0; n1_if.wdata = 32'h0; n1_if.lock = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    // Sample point of every cycle: pops the scoreboard when a read return is due.
    task automatic tick();
        exp_t e;
        @(negedge aclk);
        cyc++;
        n_tests++;
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (e.tag == 1'b0) begin
                if (e.due != cyc || m0_if.rvalid !== 1'b1 || m0_if.rdata !== e.data
                    || m1_if.rvalid !== 1'b0 || m1_if.rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL sb_read_m0 cyc=%0d got rvalid0=%b rdata0=%h rvalid1=%b rdata1=%h, need rvalid0=1 rdata0=%h rvalid1=0 rdata1=0",
                             cyc, m0_if.rvalid, m0_if.rdata, m1_if.rvalid, m1_if.rdata, e.data);
                end
            end else begin
                if (e.due != cyc || m1_if.rvalid !== 1'b1 || m1_if.rdata !== e.data
                    || m0_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL sb_read_m1 cyc=%0d got rvalid1=%b rdata1=%h rvalid0=%b rdata0=%h, need rvalid1=1 rdata1=%h rvalid0=0 rdata0=0",
                             cyc, m1_if.rvalid, m1_if.rdata, m0_if.rvalid, m0_if.rdata, e.data);
                end
            end
        end else begin
            if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 || n0_if.rvalid !== 1'b0 || n1_if.rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_no_rvalid cyc=%0d got rvalid m0=%b m1=%b n0=%b n1=%b, need all 0",
                         cyc, m0_if.rvalid, m1_if.rvalid, n0_if.rvalid, n1_if.rvalid);
            end
        end
    endtask

    task automatic push_read(input logic tag, input logic [31:0] addr);
        exp_t e;
        e.tag  = tag;
        e.data = ram_val(addr);
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        next_cycle(); areset = 1'b1; idle_all(); tick();
        next_cycle(); tick();
        next_cycle(); areset = 1'b0; tick();
    endtask

    task automatic test_reset();
        next_cycle();
        areset = 1'b1;
        m0_if.req = 1'b1; m0_if.addr = 32'h40;
        m1_if.req = 1'b1; m1_if.wen = 4'hF; m1_if.addr = 32'h44;
        tick();
        n_tests++;
        if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 || ram_if.ren !== 1'b0 || ram_if.wen !== 4'h0
            || ram_if.raddr !== 32'h0 || ram_if.wdata !== 32'h0 || owner_a !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs got gnt0=%b gnt1=%b ren=%b wen=%h raddr=%h wdata=%h owner=%b, need all 0",
                     m0_if.gnt, m1_if.gnt, ram_if.ren, ram_if.wen, ram_if.raddr, ram_if.wdata, owner_a);
        end
        do_reset();
    endtask

    task automatic test_read();
        do_reset();
        next_cycle();
        m0_if.req = 1'b1; m0_if.addr = 32'h100;
        tick();
        n_tests++;
        if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0 || ram_if.ren !== 1'b1 || ram_if.raddr !== 32'h100 || ram_if.wen !== 4'h0) begin
            n_fail++;
            $display("FAIL read_issue got gnt0=%b gnt1=%b ren=%b raddr=%h wen=%h, need 1 0 1 00000100 0",
                     m0_if.gnt, m1_if.gnt, ram_if.ren, ram_if.raddr, ram_if.wen);
        end
        push_read(1'b0, 32'h100);
        next_cycle(); idle_all(); tick();
        next_cycle(); tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] a0;
        logic [31:0] a1;
        logic        exp0;
        do_reset();
        a0 = 32'h200; a1 = 32'h300;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            m0_if.req = 1'b1; m0_if.addr = a0;
            m1_if.req = 1'b1; m1_if.addr = a1;
            tick();
            exp0 = ((i % 2) == 0);
            n_tests++;
            if (m0_if.gnt !== exp0 || m1_if.gnt !== ~exp0 || ram_if.raddr !== (exp0 ? a0 : a1)) begin
                n_fail++;
                $display("FAIL rr_beat%0d got gnt0=%b gnt1=%b raddr=%h, need gnt0=%b gnt1=%b raddr=%h",
                         i, m0_if.gnt, m1_if.gnt, ram_if.raddr, exp0, ~exp0, exp0 ? a0 : a1);
            end
            if (exp0) begin
                push_read(1'b0, a0); a0 = a0 + 32'h4;
            end else begin
                push_read(1'b1, a1); a1 = a1 + 32'h4;
            end
        end
        next_cycle(); idle_all(); tick();
        next_cycle(); tick();
    endtask

    task automatic test_write();
        do_reset();
        next_cycle();
        m1_if.req = 1'b1; m1_if.wen = 4'b0011; m1_if.addr = 32'h20; m1_if.wdata = 32'h1234_5678;
        m0_if.req = 1'b0; m0_if.wen = 4'hF; m0_if.addr = 32'h999;
        tick();
        n_tests++;
        if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0 || ram_if.wen !== 4'b0011 || ram_if.waddr !== 32'h20
            || ram_if.wdata !== 32'h1234_5678 || ram_if.ren !== 1'b0) begin
            n_fail++;
            $display("FAIL write_issue got gnt1=%b gnt0=%b wen=%b waddr=%h wdata=%h ren=%b, need 1 0 0011 00000020 12345678 0",
                     m1_if.gnt, m0_if.gnt, ram_if.wen, ram_if.waddr, ram_if.wdata, ram_if.ren);
        end
        next_cycle();
        m1_if.req = 1'b0;
        tick();
        n_tests++;
        if (ram_if.wen !== 4'h0 || m0_if.gnt !== 1'b0 || ram_if.waddr !== 32'h0) begin
            n_fail++;
            $display("FAIL write_ignored got wen=%b gnt0=%b waddr=%h, need 0000 0 00000000",
                     ram_if.wen, m0_if.gnt, ram_if.waddr);
        end
        next_cycle(); idle_all(); tick();
    endtask

    task automatic test_lock();
        logic [31:0] a0;
        do_reset();
        a0 = 32'h400;
        next_cycle();
        m0_if.req = 1'b1; m0_if.lock = 1'b1; m0_if.addr = a0;
        tick();
        n_tests++;
        if (m0_if.gnt !== 1'b1 || owner_a !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_first got gnt0=%b owner=%b, need 1 00", m0_if.gnt, owner_a);
        end
        push_read(1'b0, a0); a0 = a0 + 32'h4;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            m0_if.addr = a0; m0_if.lock = (i < 5);
            m1_if.req = 1'b1; m1_if.addr = 32'h500;
            tick();
            n_tests++;
            if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0 || owner_a !== 2'b01) begin
                n_fail++;
                $display("FAIL lock_beat%0d got gnt0=%b gnt1=%b owner=%b, need 1 0 01", i, m0_if.gnt, m1_if.gnt, owner_a);
            end
            push_read(1'b0, a0); a0 = a0 + 32'h4;
        end
        next_cycle();
        m0_if.addr = a0; m0_if.lock = 1'b0;
        tick();
        n_tests++;
        if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0 || owner_a !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_release got gnt1=%b gnt0=%b owner=%b, need 1 0 00", m1_if.gnt, m0_if.gnt, owner_a);
        end
        push_read(1'b1, 32'h500);
        next_cycle(); idle_all(); tick();
        next_cycle(); tick();
    endtask

    task automatic test_timeout();
        logic e0;
        logic e1;
        logic [1:0] eo;
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            next_cycle();
            n0_if.req = 1'b1; n0_if.lock = 1'b1; n0_if.wen = 4'hF; n0_if.addr = 32'h700 + 32'(i);
            n1_if.req = (i >= 1); n1_if.wen = 4'hF; n1_if.addr = 32'h800;
            tick();
            e0 = (i <= 4);
            e1 = (i == 6);
            eo = (i == 0 || i == 6) ? 2'b00 : 2'b01;
            n_tests++;
            if (n0_if.gnt !== e0 || n1_if.gnt !== e1 || owner_b !== eo) begin
                n_fail++;
                $display("FAIL timeout_cyc%0d got gnt0=%b gnt1=%b owner=%b, need gnt0=%b gnt1=%b owner=%b",
                         i, n0_if.gnt, n1_if.gnt, owner_b, e0, e1, eo);
            end
        end
        next_cycle(); idle_all(); tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        next_cycle();
        m1_if.req = 1'b1; m1_if.lock = 1'b1; m1_if.addr = 32'h600;
        tick();
        n_tests++;
        if (m1_if.gnt !== 1'b1 || ram_if.ren !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_grant got gnt1=%b ren=%b, need 1 1", m1_if.gnt, ram_if.ren);
        end
        next_cycle();
        areset = 1'b1; idle_all();
        tick();
        n_tests++;
        if (m1_if.rvalid !== 1'b0 || owner_a !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_drop got rvalid1=%b owner=%b, need 0 00", m1_if.rvalid, owner_a);
        end
        next_cycle(); tick();
        next_cycle(); areset = 1'b0; tick();
        next_cycle();
        m0_if.req = 1'b1; m0_if.addr = 32'h610;
        m1_if.req = 1'b1; m1_if.addr = 32'h620;
        tick();
        n_tests++;
        if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0 || owner_a !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_after got gnt0=%b gnt1=%b owner=%b, need 1 0 00", m0_if.gnt, m1_if.gnt, owner_a);
        end
        push_read(1'b0, 32'h610);
        next_cycle(); idle_all(); tick();
        next_cycle(); tick();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_lock();
        test_timeout();
        test_reset_midop();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending reads, need 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/simram_port_arbiter.md
Name: simram_port_arbiter

Overview:
- Shares the simulation RAM port of the verilator top (ram_ren/ram_raddr/ram_rdata/ram_wen/ram_waddr/ram_wdata) between two single-beat requesters.
- m0 is the SoC memory bridge; m1 is the testbench loader/debug path.
- Arbitration is round-robin, with an optional burst lock and a starvation timeout.
- Read data is steered back to the master that issued the read.

Parameters:
DATA_WIDTH, 32, RAM data width; byte-enable width is DATA_WIDTH/8
BUS_WIDTH, 32, RAM address width
MAX_HOLD, 16, max cycles a locked owner may block a requesting peer (>=1)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
m0_req  in  1  m0 beat request; addr/wen/wdata/lock held stable until m0_gnt
m0_wen  in  DATA_WIDTH/8  byte enables; all-zero = read, nonzero = write
m0_addr  in  BUS_WIDTH  beat address
m0_wdata  in  DATA_WIDTH  write data
m0_lock  in  1  keep ownership after this beat
m0_gnt  out  1  beat issued to RAM this cycle
m0_rvalid  out  1  read data valid for m0
m0_rdata  out  DATA_WIDTH  read data
m1_req, m1_wen, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as m0
ram_ren  out  1  RAM read enable
ram_raddr  out  BUS_WIDTH  RAM read address
ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_ren
ram_wen  out  DATA_WIDTH/8  RAM write byte enables
ram_waddr  out  BUS_WIDTH  RAM write address
ram_wdata  out  DATA_WIDTH  RAM write data
owner  out  2  debug: 00 idle, 01 LOCK0, 10 LOCK1

Behaviour:
- Sequential state:
  - FSM state {IDLE, LOCK0, LOCK1}.
  - rr pointer (last winner).
  - hold counter cnt, width clog2(MAX_HOLD+1).
  - rd_pend and rd_tag.
- Reset (areset=1, asynchronous):
  - State, registers and outputs: state=IDLE, rr=1 (m0 wins first), cnt=0, rd_pend=0, owner=00.
  - Combinational outputs are forced to 0 while areset=1: gnt, rvalid, ram_ren, ram_wen, addr, wdata.
- Grant (combinational from current state and req); at most one gnt per cycle:
  - IDLE, single requester: that requester wins.
  - IDLE, both requesting: the master other than rr wins.
  - LOCKn: only mn may be granted, whenever mn_req=1. Exception: timeout cycle (below).
- Issue:
  - Granted beat drives ram_raddr=ram_waddr=addr and ram_wdata=wdata.
  - Read: ram_ren=1, ram_wen=0. Write: ram_ren=0, ram_wen=wen.
  - No grant: ram_ren=0, ram_wen=0, addr/wdata driven 0.
- rr updates to the winner on every grant.
- Lock transitions, on a granted beat by mn:
  - lock=1: go to / stay in LOCKn.
  - lock=0: go to IDLE.
- Timeout counter:
  - cnt clears on entering LOCKn.
  - In LOCKn, cnt increments each cycle the other master has req=1. It holds otherwise, including cycles where mn is idle.
- Timeout:
  - When cnt==MAX_HOLD in LOCKn, that cycle grants nothing, sets state=IDLE and rr=n.
  - The peer therefore wins the next cycle.
  - mn's lock is dropped; mn must re-acquire.
- Read return:
  - A read grant sets rd_pend=1, rd_tag=winner for the next cycle; otherwise rd_pend=0.
  - Next cycle: m{rd_tag}_rvalid=1 and m{rd_tag}_rdata=ram_rdata. The other master's rdata is 0.
  - Latency from gnt to rvalid is exactly 1 cycle. Back-to-back reads are supported at 1 beat/cycle.
- Writes produce no response; gnt is completion.
- Reset mid-operation: an outstanding read is dropped (no rvalid) and any lock is cleared.
- Simultaneous events:
  - Lock release beat and peer request in the same cycle: the release beat is granted; the peer wins next cycle via rr.
  - Timeout and a owner beat in the same cycle: timeout takes priority and the owner gets no gnt.
- Requester with wen nonzero and req=0: ignored.

Test Plan:
- Reset, then m0 read addr 0x100 with ram_rdata=0xDEADBEEF next cycle -> m0_gnt cycle 0, ram_ren=1, ram_raddr=0x100; m0_rvalid=1, m0_rdata=0xDEADBEEF cycle 1; m1_rvalid=0.
- Both masters request continuously, no lock -> grants alternate m0,m1,m0,m1; first grant goes to m0.
- m1 write, wen=4'b0011, addr 0x20, wdata 0x12345678 -> ram_wen=0011, ram_waddr=0x20, ram_ren=0, no rvalid.
- m0 holds lock=1 for 5 beats then lock=0 while m1 requests (MAX_HOLD=16) -> m1 is not granted during the lock; owner=01 during the lock; after the release beat m1 is granted the next cycle.
- m0 locks and holds lock with MAX_HOLD=4 while m1 requests -> after 4 counted cycles one cycle with no gnt; m1_gnt the next cycle; owner=00.
- areset asserted the cycle after an m1 read grant -> m1_rvalid never asserts; after release, state=IDLE and m0 wins the first contested cycle.
